ysyx_axi4_sram_slave: RTL
=========================

Name: ysyx_axi4_sram_slave

Overview:
- AXI4 responder (slave) modelling on-chip SRAM, 64-bit data bus.
- Opposite end of the core's AXI4 master bus arbiter; sits on the io_master_* bus in standalone/sim configs in place of the SoC memory.
- Independent read and write channel FSMs with FIXED/INCR bursts and byte strobes.
- Optional LFSR-throttled ready signals for back-pressure testing.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 64, data bus width (fixed 64; 8 strobe bits)
- ID_W, 4, AXI ID width
- DEPTH_LOG2, 12, log2 of number of 64-bit words
- BASE, 32'h8000_0000, base address of the SRAM window
- LFSR_EN, 0, 1 = gate arready/awready/wready with a 20-bit LFSR bit

Ports:
- clk input 1 clock
- rst input 1 reset, synchronous, active-high
- arid input ID_W; araddr input ADDR_W; arlen input 8; arsize input 3; arburst input 2; arvalid input 1; arready output 1
- rid output ID_W; rdata output 64; rresp output 2; rlast output 1; rvalid output 1; rready input 1
- awid input ID_W; awaddr input ADDR_W; awlen input 8; awsize input 3; awburst input 2; awvalid input 1; awready output 1
- wdata input 64; wstrb input 8; wlast input 1; wvalid input 1; wready output 1
- bid output ID_W; bresp output 2; bvalid output 1; bready input 1

Behaviour:
- Reset: all outputs 0 (arready, awready, wready, rvalid, bvalid, rlast, rdata, rresp, bresp, rid, bid). LFSR reset to 1. Memory contents are not reset.
- Reset mid-burst aborts both FSMs to idle on the next edge; no B or R response is produced for the aborted transaction.
- Address map: word index = addr[DEPTH_LOG2+2:3]. In range iff BASE <= addr < BASE + 8*2^DEPTH_LOG2.
- Read FSM R_IDLE -> R_BURST:
  - R_IDLE: arready = ready_gate (1 when LFSR_EN = 0, else lfsr[19]).
  - On AR handshake: latch id, addr, len, burst, size; beat counter = 0. Next cycle rvalid = 1 with beat 0.
  - rdata = mem[word]; rresp = 00 (OKAY).
  - Out-of-range address or arburst = 2'b10 (WRAP) or 2'b11: rresp = 10 (SLVERR), rdata = 0, for every beat.
  - rvalid and all R fields stay stable until rready; a beat advances only on the handshake.
  - Back-to-back beats: after a handshake, the next beat is valid in the following cycle. Full rate is one beat/cycle with rready held high.
  - rlast = 1 iff counter == len. Handshake on the last beat returns to R_IDLE; arready is re-asserted in the next cycle.
- Write FSM W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: awready = ready_gate. On AW handshake: latch id, addr, len, burst; beat counter = 0; error flag set if out-of-range or unsupported burst.
  - W_DATA: wready = ready_gate. On W handshake, write each byte i where wstrb[i] = 1 into mem[word]. No write occurs when the error flag is set.
  - The burst ends on beat counter == len regardless of wlast. Error flag is set if wlast is asserted at counter != len, or deasserted at counter == len.
  - W_RESP: bvalid = 1, bid = latched id, bresp = error ? 10 : 00. Held until bready; then return to W_IDLE.
- Burst address update, applied per handshaked beat:
  - INCR: addr += (1 << size), carried through the full ADDR_W.
  - FIXED: addr unchanged.
  - size > 3 is treated as an error (SLVERR).
- Sub-word reads return the full 64-bit word; lane selection is the master's job. Writes are strobe-driven only.
- Simultaneous read and write to the same word in the same cycle: the read beat returns the old data. The write is visible to reads sampled from the next cycle on.
- AR and AW handshakes may occur in the same cycle; the channels are fully independent. There is no outstanding-transaction queue: one read and one write in flight maximum.
- LFSR: lfsr <= {lfsr[18:0], lfsr[19]^lfsr[18]} every cycle when not in reset.

Test Plan:
- Single write then read: AW addr 0x8000_0008, len 0, W data 0x1122334455667788, strb 0xFF. Required: bvalid 1 cycle after the W handshake, bresp 00. Then AR same addr -> rdata 0x1122334455667788, rlast 1, rresp 00.
- Strobed write: pre-fill 0x8000_0010 with 0; write 0xAABBCCDD_EEFF0011, strb 0x0F. Readback must be 0x00000000_EEFF0011.
- INCR read burst: arlen 3, size 3, from 0x8000_0000 over pre-filled words 0..3 = 1,2,3,4. Required: 4 beats returning 1,2,3,4, rlast only on beat 3, arid echoed on rid. With rready toggling 1/0, rdata must hold stable while rready = 0.
- Error cases:
  - Read of 0x1000_0000 -> rresp 10, rdata 0.
  - Write with wlast high on beat 0 of len 1 -> 2 beats accepted, bresp 10, memory unchanged.
- Concurrency: AR and AW handshake in the same cycle to the same word; the W beat and the first R beat coincide. R must return the old value; a later read returns the new value.
- Reset mid-burst: assert rst during beat 1 of a len 3 read. Next cycle: rvalid 0, arready 0. After release, arready 1 and a new read completes normally; check with LFSR_EN = 1 for eventual completion within 100 cycles.

Source files
------------

// File: rtl/ysyx_axi4_sram_slave.sv
// AXI4 responder modelling a word-addressed on-chip SRAM behind the core's AXI4 master.
// Read and write channels run independent FSMs; each accepts one transaction at a time.
// FIXED and INCR bursts, byte strobes; WRAP, size > 3 and out-of-window beats answer SLVERR.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   ar*/r*                read address / read data channels
//   aw*/w*/b*             write address / write data / write response channels
// LFSR_EN = 1 gates arready/awready/wready with a free-running LFSR bit for back-pressure.
module ysyx_axi4_sram_slave #(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 64,
  parameter int unsigned       ID_W       = 4,
  parameter int unsigned       DEPTH_LOG2 = 12,
  parameter logic [ADDR_W-1:0] BASE       = 32'h8000_0000,
  parameter bit                LFSR_EN    = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_W-1:0]       arid,
  input  logic [ADDR_W-1:0]     araddr,
  input  logic [7:0]            arlen,
  input  logic [2:0]            arsize,
  input  logic [1:0]            arburst,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [ID_W-1:0]       rid,
  output logic [DATA_W-1:0]     rdata,
  output logic [1:0]            rresp,
  output logic                  rlast,
  output logic                  rvalid,
  input  logic                  rready,
  input  logic [ID_W-1:0]       awid,
  input  logic [ADDR_W-1:0]     awaddr,
  input  logic [7:0]            awlen,
  input  logic [2:0]            awsize,
  input  logic [1:0]            awburst,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  input  logic                  wlast,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [ID_W-1:0]       bid,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready
);

  localparam int unsigned Words = 1 << DEPTH_LOG2;
  localparam logic [ADDR_W:0] Limit = {1'b0, BASE} + (ADDR_W+1)'(Words * 8);

  typedef enum logic {RIdle, RBurst} r_state_e;
  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;

  // Beat is unserviceable: outside the window, WRAP/reserved burst, or wider than the bus.
  function automatic logic f_bad(input logic [ADDR_W-1:0] a, input logic [1:0] burst,
                                 input logic [2:0] size);
    logic [ADDR_W:0] ax;
    ax = {1'b0, a};
    return (a < BASE) || (ax >= Limit) || burst[1] || (size > 3'd3);
  endfunction

  function automatic logic [ADDR_W-1:0] f_next(input logic [ADDR_W-1:0] a,
                                               input logic [1:0] burst, input logic [2:0] size);
    return (burst == 2'b01) ? a + (ADDR_W'(1) << size) : a;
  endfunction

  logic [DATA_W-1:0] r_mem [Words];

  // r_run keeps every ready low while rst is high and for the edge it is sampled on.
  logic        r_run;
  logic [19:0] r_lfsr;
  logic        w_gate;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_run  <= 1'b0;
      r_lfsr <= 20'd1;
    end else begin
      r_run  <= 1'b1;
      r_lfsr <= {r_lfsr[18:0], r_lfsr[19] ^ r_lfsr[18]};
    end
  end

  assign w_gate = !LFSR_EN || r_lfsr[19];

  // ---------------- read channel ----------------
  r_state_e          r_rstate, w_rstate_d;
  logic [ADDR_W-1:0] r_raddr, w_raddr_nxt, w_rd_addr;
  logic [7:0]        r_rlen, r_rcnt;
  logic [2:0]        r_rsize, w_rd_size;
  logic [1:0]        r_rburst, w_rd_burst, r_rresp;
  logic [ID_W-1:0]   r_rid;
  logic [DATA_W-1:0] r_rdata;
  logic              w_ar_hs, w_r_hs, w_rd_bad;

  assign rvalid  = (r_rstate == RBurst);
  assign rlast   = rvalid && (r_rcnt == r_rlen);
  assign rid     = r_rid;
  assign rdata   = r_rdata;
  assign rresp   = r_rresp;
  assign w_ar_hs = arvalid && arready;
  assign w_r_hs  = rvalid && rready;

  always_comb begin
    w_rstate_d = r_rstate;
    arready    = 1'b0;
    unique case (r_rstate)
      RIdle: begin
        arready = r_run && w_gate;
        if (arvalid && arready) w_rstate_d = RBurst;
      end
      RBurst: if (rready && rlast) w_rstate_d = RIdle;
      default: w_rstate_d = RIdle;
    endcase
  end

  // Data for the beat about to be presented is fetched at the handshake that exposes it,
  // so a stalled beat stays stable and a same-cycle write is seen only by later beats.
  assign w_raddr_nxt = f_next(r_raddr, r_rburst, r_rsize);
  assign w_rd_addr   = w_ar_hs ? araddr : w_raddr_nxt;
  assign w_rd_burst  = w_ar_hs ? arburst : r_rburst;
  assign w_rd_size   = w_ar_hs ? arsize : r_rsize;
  assign w_rd_bad    = f_bad(w_rd_addr, w_rd_burst, w_rd_size);

  always_ff @(posedge clk) begin
    if (rst) r_rstate <= RIdle;
    else     r_rstate <= w_rstate_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rid    <= '0;
      r_raddr  <= '0;
      r_rlen   <= '0;
      r_rsize  <= '0;
      r_rburst <= '0;
      r_rcnt   <= '0;
      r_rdata  <= '0;
      r_rresp  <= '0;
    end else if (w_ar_hs || (w_r_hs && !rlast)) begin
      if (w_ar_hs) begin
        r_rid    <= arid;
        r_rlen   <= arlen;
        r_rsize  <= arsize;
        r_rburst <= arburst;
        r_rcnt   <= '0;
      end else begin
        r_rcnt   <= r_rcnt + 8'd1;
      end
      r_raddr <= w_rd_addr;
      r_rdata <= w_rd_bad ? '0 : r_mem[w_rd_addr[DEPTH_LOG2+2:3]];
      r_rresp <= w_rd_bad ? 2'b10 : 2'b00;
    end
  end

  // ---------------- write channel ----------------
  w_state_e          r_wstate, w_wstate_d;
  logic [ADDR_W-1:0] r_waddr;
  logic [7:0]        r_wlen, r_wcnt;
  logic [2:0]        r_wsize;
  logic [1:0]        r_wburst;
  logic [ID_W-1:0]   r_wid;
  logic              r_werr, w_aw_hs, w_w_hs, w_wlast_beat, w_wbeat_bad, w_we;

  assign bid          = r_wid;
  assign bresp        = (bvalid && r_werr) ? 2'b10 : 2'b00;
  assign w_aw_hs      = awvalid && awready;
  assign w_w_hs       = wvalid && wready;
  assign w_wlast_beat = (r_wcnt == r_wlen);
  // A wlast that disagrees with the beat count poisons the burst starting at that beat.
  assign w_wbeat_bad  = f_bad(r_waddr, r_wburst, r_wsize) || (wlast != w_wlast_beat);
  assign w_we         = w_w_hs && !r_werr && !w_wbeat_bad;

  always_comb begin
    w_wstate_d = r_wstate;
    awready    = 1'b0;
    wready     = 1'b0;
    bvalid     = 1'b0;
    unique case (r_wstate)
      WIdle: begin
        awready = r_run && w_gate;
        if (awvalid && awready) w_wstate_d = WData;
      end
      WData: begin
        wready = r_run && w_gate;
        if (wvalid && wready && w_wlast_beat) w_wstate_d = WResp;
      end
      WResp: begin
        bvalid = 1'b1;
        if (bready) w_wstate_d = WIdle;
      end
      default: w_wstate_d = WIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_wstate <= WIdle;
    else     r_wstate <= w_wstate_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wid    <= '0;
      r_waddr  <= '0;
      r_wlen   <= '0;
      r_wsize  <= '0;
      r_wburst <= '0;
      r_wcnt   <= '0;
      r_werr   <= 1'b0;
    end else if (w_aw_hs) begin
      r_wid    <= awid;
      r_waddr  <= awaddr;
      r_wlen   <= awlen;
      r_wsize  <= awsize;
      r_wburst <= awburst;
      r_wcnt   <= '0;
      r_werr   <= f_bad(awaddr, awburst, awsize);
    end else if (w_w_hs) begin
      r_wcnt  <= r_wcnt + 8'd1;
      r_waddr <= f_next(r_waddr, r_wburst, r_wsize);
      r_werr  <= r_werr || w_wbeat_bad;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int i = 0; i < DATA_W / 8; i++) begin
        if (wstrb[i]) r_mem[r_waddr[DEPTH_LOG2+2:3]][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule
